// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: main control FSM for the multi-cycle RV32I datapath.
// Latency: R/I 4, lw 5, sw 4, branch 3, jal 4 cycles; +1 per cycle of mem_ready_i low in FETCH/MEMRD/MEMWR.
// Backpressure: FETCH, MEMRD and MEMWR hold their request until mem_ready_i; elsewhere mem_ready_i is ignored.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset (outputs forced to 0 while high)
//   instr_i          instruction register contents (stable from DECODE until back in FETCH)
//   zero_i           ALU zero flag, used for beq/bne
//   mem_ready_i      memory accepted the write / returned the read data this cycle
//   mem_*_o, adr_src_o               memory request, write qualifier, address select
//   ir_write_o, pc_write_o, reg_write_o  datapath write strobes
//   alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o  datapath selects
//   ALU_Control_o    4-bit ALU operation code
//   illegal_o        one-cycle pulse in DECODE for an unsupported instruction
//   retire_o         one-cycle pulse in the final cycle of each legal instruction
module riscv_multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        adr_src_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        reg_write_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  result_src_o,
  output logic [1:0]  imm_src_o,
  output logic [3:0]  ALU_Control_o,
  output logic        illegal_o,
  output logic        retire_o
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BR, S_JAL
  } state_e;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       legal;
  logic [1:0] imm_dec;
  logic       unused_instr;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign f7b5   = instr_i[30];
  // Register indices and immediate bits belong to the datapath, not this block.
  assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  // Only the subset the datapath's ALU can execute is legal: no SLT/SLTU,
  // no arithmetic right shift, word-sized loads/stores, beq/bne only.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW: legal = (funct3 == 3'b010);
      OP_R:   legal = f7b5 ? (funct3 == 3'b000)
                           : (funct3 != 3'b010 && funct3 != 3'b011);
      OP_I:   legal = (funct3 != 3'b010 && funct3 != 3'b011) &&
                      !(funct3 == 3'b101 && f7b5);
      OP_BR:  legal = (funct3 == 3'b000 || funct3 == 3'b001);
      OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_dec = 2'b00;
    case (opcode)
      OP_SW:  imm_dec = 2'b01;
      OP_BR:  imm_dec = 2'b10;
      OP_JAL: imm_dec = 2'b11;
      default: imm_dec = 2'b00;
    endcase
  end

  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b001:  return ALU_SLL;
      3'b101:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) state_d = S_FETCH;
        else begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_BR:        state_d = S_BR;
            default:      state_d = S_JAL;
          endcase
        end
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BR:     state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic; everything is gated off while reset is asserted so an
  // interrupted transaction never leaks a write or PC strobe.
  always_comb begin
    mem_req_o     = 1'b0;
    mem_write_o   = 1'b0;
    adr_src_o     = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    result_src_o  = 2'b00;
    imm_src_o     = 2'b00;
    ALU_Control_o = 4'b0000;
    illegal_o     = 1'b0;
    retire_o      = 1'b0;
    if (!rst_i) begin
      imm_src_o = imm_dec;
      case (state_q)
        S_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o    = 1'b1;
            pc_write_o    = 1'b1;
            alu_src_b_o   = 2'b10;
            result_src_o  = 2'b10;
            ALU_Control_o = ALU_ADD;
          end
        end
        S_DECODE: begin
          // Branch/jump target = oldPC + imm, parked in ALUOut.
          alu_src_a_o   = 2'b01;
          alu_src_b_o   = 2'b01;
          ALU_Control_o = ALU_ADD;
          illegal_o     = !legal;
        end
        S_MEMADR: begin
          alu_src_a_o   = 2'b10;
          alu_src_b_o   = 2'b01;
          ALU_Control_o = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req_o = 1'b1;
          adr_src_o = 1'b1;
        end
        S_MEMWB: begin
          result_src_o = 2'b01;
          reg_write_o  = 1'b1;
          retire_o     = 1'b1;
        end
        S_MEMWR: begin
          mem_req_o   = 1'b1;
          mem_write_o = 1'b1;
          adr_src_o   = 1'b1;
          retire_o    = mem_ready_i;
        end
        S_EXECR: begin
          alu_src_a_o   = 2'b10;
          ALU_Control_o = alu_from_funct3(funct3, f7b5);
        end
        S_EXECI: begin
          alu_src_a_o   = 2'b10;
          alu_src_b_o   = 2'b01;
          ALU_Control_o = alu_from_funct3(funct3, 1'b0);
        end
        S_ALUWB: begin
          reg_write_o = 1'b1;
          retire_o    = 1'b1;
        end
        S_BR: begin
          alu_src_a_o   = 2'b10;
          ALU_Control_o = ALU_SUB;
          pc_write_o    = funct3[0] ? !zero_i : zero_i;
          retire_o      = 1'b1;
        end
        S_JAL: begin
          // PC takes the target from ALUOut while the ALU forms the link value.
          alu_src_a_o   = 2'b01;
          alu_src_b_o   = 2'b10;
          ALU_Control_o = ALU_ADD;
          pc_write_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: self-checking bench for the multi-cycle control FSM.
// Builds an expected per-cycle output trace from the instruction class and compares every cycle.
// Drives random don't-care inputs (mem_ready_i, zero_i) wherever the block must ignore them.
module tb_riscv_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
  logic [1:0]  alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o;
  logic [3:0]  ALU_Control_o;
  logic        illegal_o, retire_o;

  riscv_multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
    .adr_src_o(adr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .result_src_o(result_src_o), .imm_src_o(imm_src_o), .ALU_Control_o(ALU_Control_o),
    .illegal_o(illegal_o), .retire_o(retire_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b, rs, imm;
    logic [3:0] alu;
    logic ill, ret;
  } out_t;

  typedef struct packed {
    out_t exp;
    logic rdy;
    logic zero;
  } cyc_t;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;
  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_JAL = 6;

  out_t dut_o;
  assign dut_o = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                  alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o, ALU_Control_o,
                  illegal_o, retire_o};

  int   n_checks = 0;
  int   n_errors = 0;
  int   last_len;
  cyc_t seq[$];

  // ---------------- reference model ----------------
  function automatic int klass(input logic [31:0] ins);
    logic [2:0] f3 = ins[14:12];
    logic       b30 = ins[30];
    case (ins[6:0])
      7'b0000011: return (f3 == 3'd2) ? K_LW : K_ILL;
      7'b0100011: return (f3 == 3'd2) ? K_SW : K_ILL;
      7'b0110011: begin
        if (f3 == 3'd2 || f3 == 3'd3) return K_ILL;
        if (b30 && f3 != 3'd0) return K_ILL;
        return K_R;
      end
      7'b0010011: begin
        if (f3 == 3'd2 || f3 == 3'd3) return K_ILL;
        if (b30 && f3 == 3'd5) return K_ILL;
        return K_I;
      end
      7'b1100011: return (f3 <= 3'd1) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [31:0] ins);
    if (ins[6:0] == 7'b0100011) return 2'b01;
    if (ins[6:0] == 7'b1100011) return 2'b10;
    if (ins[6:0] == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Operation table indexed by funct3: 000 add, 001 sll, 100 xor, 101 srl, 110 or, 111 and.
  function automatic logic [3:0] op_of(input logic [2:0] f3);
    logic [3:0] tab [8];
    tab = '{4'b0010, 4'b0100, 4'b0010, 4'b0010, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    return tab[f3];
  endfunction

  // rdy/z: 0 or 1 to fix the value, -1 for a random don't-care.
  function automatic void push(input out_t o, input int rdy, input int z);
    cyc_t c;
    c.exp  = o;
    c.rdy  = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
    c.zero = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
    seq.push_back(c);
  endfunction

  function automatic void build_seq(input logic [31:0] ins, input int fw, input int mw, input int z);
    out_t b, o;
    int   k = klass(ins);
    seq.delete();
    b = '0;
    b.imm = imm_of(ins);
    for (int i = 0; i < fw; i++) begin
      o = b; o.mem_req = 1; push(o, 0, -1);
    end
    o = b; o.mem_req = 1; o.ir_write = 1; o.pc_write = 1; o.b = 2; o.rs = 2; o.alu = ADD;
    push(o, 1, -1);
    o = b; o.a = 1; o.b = 1; o.alu = ADD; o.ill = (k == K_ILL);
    push(o, -1, -1);
    case (k)
      K_R, K_I: begin
        o = b; o.a = 2; o.b = (k == K_I) ? 2'd1 : 2'd0;
        o.alu = (k == K_R && ins[14:12] == 3'd0 && ins[30]) ? SUB : op_of(ins[14:12]);
        push(o, -1, -1);
        o = b; o.reg_write = 1; o.ret = 1; push(o, -1, -1);
      end
      K_LW, K_SW: begin
        o = b; o.a = 2; o.b = 1; o.alu = ADD; push(o, -1, -1);
        for (int i = 0; i <= mw; i++) begin
          o = b; o.mem_req = 1; o.adr_src = 1; o.mem_write = (k == K_SW);
          o.ret = (k == K_SW) && (i == mw);
          push(o, (i == mw) ? 1 : 0, -1);
        end
        if (k == K_LW) begin
          o = b; o.rs = 1; o.reg_write = 1; o.ret = 1; push(o, -1, -1);
        end
      end
      K_BR: begin
        o = b; o.a = 2; o.alu = SUB; o.ret = 1;
        o.pc_write = ins[12] ? (z == 0) : (z == 1);
        push(o, -1, z);
      end
      K_JAL: begin
        o = b; o.a = 1; o.b = 2; o.alu = ADD; o.pc_write = 1; push(o, -1, -1);
        o = b; o.reg_write = 1; o.ret = 1; push(o, -1, -1);
      end
      default: ;
    endcase
  endfunction

  // Plays seq[0..n-1]; entered and left 1 time unit after a rising edge.
  task automatic play(input string name, input int n);
    last_len = 0;
    for (int i = 0; i < n; i++) begin
      mem_ready_i = seq[i].rdy;
      zero_i      = seq[i].zero;
      @(negedge clk_i);
      n_checks++;
      if (dut_o !== seq[i].exp) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %h want %h", name, i, dut_o, seq[i].exp);
      end
      if (last_len == 0 && (retire_o === 1'b1 || illegal_o === 1'b1)) last_len = i + 1;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [31:0] ins, input int fw,
                           input int mw, input int z, input int exp_len);
    instr_i = ins;
    build_seq(ins, fw, mw, z);
    play(name, seq.size());
    if (exp_len != 0) begin
      n_checks++;
      if (last_len !== exp_len) begin
        n_errors++;
        $display("FAIL %s_latency: got %0d want %0d", name, last_len, exp_len);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1;
    for (int i = 0; i < 4; i++) begin
      instr_i = $urandom; zero_i = 1'($urandom); mem_ready_i = 1'($urandom);
      #4;
      n_checks++;
      if (dut_o !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: got %h want 0", dut_o);
      end
    end
    @(posedge clk_i); #1;
    instr_i = 32'h0000_0013; rst_i = 0; mem_ready_i = 0;
    #1;
    n_checks++;
    if (dut_o !== 20'h80000) begin
      n_errors++;
      $display("FAIL reset_release_fetch: got %h want %h", dut_o, 20'h80000);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_add();    run_instr("add", 32'h002081B3, 0, 0, -1, 4); endtask
  task automatic test_sub();    run_instr("sub", 32'h402081B3, 0, 0, -1, 4); endtask
  task automatic test_branch();
    run_instr("beq_taken",  32'h00208463, 0, 0, 1, 3);
    run_instr("beq_not",    32'h00208463, 0, 0, 0, 3);
    run_instr("bne_taken",  32'h00209463, 1, 0, 0, 4);
  endtask
  task automatic test_load_wait();
    run_instr("lw_wait", 32'h0040A283, 0, 3, -1, 8);
    run_instr("lw_fast", 32'h0040A283, 0, 0, -1, 5);
  endtask
  task automatic test_store_jal();
    run_instr("sw",  32'h0050A223, 0, 0, -1, 4);
    run_instr("jal", 32'h008000EF, 2, 0, -1, 6);
  endtask
  task automatic test_illegal();
    run_instr("slt",  32'h0000A0B3, 0, 0, -1, 2);
    run_instr("srai", 32'h4010D093, 0, 0, -1, 2);
  endtask

  task automatic test_reset_mid_store();
    out_t f;
    instr_i = 32'h0050A223;
    build_seq(instr_i, 0, 5, -1);
    play("rst_store_pre", 4);
    mem_ready_i = 0; zero_i = 0;
    #1;
    rst_i = 1;
    #1;
    n_checks++;
    if (dut_o !== '0) begin
      n_errors++;
      $display("FAIL rst_store_immediate: got %h want 0", dut_o);
    end
    mem_ready_i = 1;
    @(posedge clk_i); #1;
    n_checks++;
    if (dut_o !== '0) begin
      n_errors++;
      $display("FAIL rst_store_held: got %h want 0", dut_o);
    end
    rst_i = 0; mem_ready_i = 0;
    #1;
    f = '0; f.mem_req = 1; f.imm = 2'b01;
    n_checks++;
    if (dut_o !== f) begin
      n_errors++;
      $display("FAIL rst_store_fetch: got %h want %h", dut_o, f);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
    for (int t = 0; t < 80; t++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 7)];
      if ((ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) && $urandom_range(0, 1) == 1)
        ins[14:12] = 3'b010;
      run_instr("random", ins, $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 1), 0);
    end
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_add",  32'h002081B3, 0, 0, -1, 4);
    run_instr("b2b_lw",   32'h0040A283, 0, 0, -1, 5);
    run_instr("b2b_andi", 32'h0FF0F093, 0, 0, -1, 4);
    run_instr("b2b_bne",  32'h00209463, 0, 0, 1, 3);
  endtask

  initial begin
    rst_i = 1; instr_i = '0; zero_i = 0; mem_ready_i = 0;
    test_reset();
    test_add();
    test_sub();
    test_branch();
    test_load_wait();
    test_store_jal();
    test_illegal();
    test_reset_mid_store();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I datapath variant. It decodes the instruction-register fields and sequences the datapath through fetch, decode, execute, memory and writeback. It is the driving end of the ALU operation interface: it produces the 4-bit ALU control code and consumes the ALU zero flag. Memory accesses use a request/ready handshake, so each instruction takes a variable number of cycles.

Parameters:
None. The ALU codes are fixed: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
instr_i  in  32  instruction register contents; stable from DECODE until the return to FETCH
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory accepted the request (write) or returned data (read) this cycle
mem_req_o  out  1  memory request
mem_write_o  out  1  request is a write
adr_src_o  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write_o  out  1  load the instruction register (and oldPC)
pc_write_o  out  1  load the PC
reg_write_o  out  1  register-file write
alu_src_a_o  out  2  operand A select: 00 = PC, 01 = oldPC, 10 = rs1
alu_src_b_o  out  2  operand B select: 00 = rs2, 01 = imm, 10 = constant 4
result_src_o  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result
imm_src_o  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J (decoded from opcode in every state)
ALU_Control_o  out  4  ALU operation
illegal_o  out  1  one-cycle pulse when an unsupported instruction is detected in DECODE
retire_o  out  1  one-cycle pulse in the final cycle of each legal instruction

Behaviour:
- Reset
  - Asserting rst_i forces the state to FETCH.
  - While rst_i is high, all 1-bit outputs are 0 and all multi-bit outputs are 0.
  - Reset mid-transaction abandons the transaction; no write or PC strobe is issued.
- Output timing: outputs are combinational from the state, instr_i, zero_i and mem_ready_i. Selects and strobes not listed for a state are 0.
- FETCH: mem_req=1, adr_src=0.
  - Hold in FETCH while mem_ready_i=0.
  - On mem_ready_i=1: ir_write=1, pc_write=1, A=PC, B=4, ADD, result_src=10, then go to DECODE.
- DECODE: A=oldPC, B=imm, ADD (precomputes the branch target). Next state by opcode:
  - 0000011 lw or 0100011 sw -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BR
  - 1101111 -> JAL
  - Anything else, including the cases below, is illegal: illegal_o=1, then go to FETCH.
    - funct3 010/011 on ALU ops
    - SRA/SRAI (funct7[5]=1 with funct3 101)
    - funct7[5]=1 on R-type with funct3 other than 000 or 101
    - lw/sw with funct3 not equal to 010
    - branch with funct3 not 000 or 001
- MEMADR: A=rs1, B=imm, ADD. Then lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, adr_src=1. Wait for mem_ready_i, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1, then go to FETCH.
- MEMWR: mem_req=1, mem_write=1, adr_src=1, held until mem_ready_i. On ready: retire=1, then go to FETCH.
- EXECR: A=rs1, B=rs2. ALU code from funct3:
  - 000 -> ADD, or SUB if funct7[5]=1
  - 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL
  - Then go to ALUWB.
- EXECI: A=rs1, B=imm. Same funct3 map, except 000 is always ADD. Then go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1, then go to FETCH.
- BR: A=rs1, B=rs2, SUB, result_src=00. pc_write = zero_i for beq (funct3 000), !zero_i for bne (funct3 001). retire=1, then go to FETCH.
- JAL: A=oldPC, B=4, ADD, result_src=00, pc_write=1 (PC takes the precomputed target), then go to ALUWB.
- Latency with mem_ready_i tied to 1:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - Each cycle of mem_ready_i low adds one cycle.
- mem_ready_i is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Add: instr 0x002081B3 (add x3,x1,x2), ready=1 -> FETCH, DECODE, EXECR (ALU_Control_o=0010, A=10, B=00), ALUWB (reg_write=1, retire=1); 4 cycles total.
- Sub: instr 0x402081B3 -> EXECR drives ALU_Control_o=0110; no illegal_o.
- Branch: instr 0x00208463 (beq) -> BR drives SUB.
  - zero_i=1: pc_write=1.
  - zero_i=0: pc_write=0.
  - retire=1 in both cases.
- Load with wait states: instr 0x0040A283 (lw x5,4(x1)), mem_ready_i low for 3 cycles in MEMRD -> mem_req=1 and adr_src=1 held for 4 cycles; then MEMWB with result_src=01 and reg_write=1; 8 cycles total.
- Illegal: instr 0x0000A0B3 (slt) -> illegal_o pulses in DECODE; next state FETCH; reg_write never asserted.
- Reset mid-store: assert rst_i during MEMWR with mem_ready_i=0 -> all outputs 0 immediately, without waiting for a clock edge; after release the block is in FETCH with mem_req=1, mem_write=0.
